// File: rtl/pipe_stage_register_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_register_pkg
// Description : Shared general definitions for the pipeline-stage register.
//               Holds the stage occupancy state type, the machine word width,
//               the packed control bundle layout and its NOP encoding. It also
//               provides a helper that maps a state to its entry count.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_stage_register_pkg;

    // Machine word: default width of the datapath payload.
    localparam int unsigned WORD = 32;

    // Occupancy of the two-slot stage register.
    //   EMPTY : nothing held
    //   ONE   : main slot held (drives the outputs)
    //   FULL  : main and skid slots held
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    // Packed control bundle carried alongside the payload (16 bits).
    typedef struct packed {
        logic       mem_wr;   // memory write enable
        logic       mem_rd;   // memory read enable
        logic       reg_wr;   // register-file write enable
        logic [4:0] rd_sel;   // destination register index
        logic [3:0] alu_op;   // ALU operation select
        logic [1:0] src_sel;  // ALU operand-B source select
        logic [1:0] wb_sel;   // write-back source select
    } ctrl_bundle_t;

    // NOP control word: no memory write, no memory read, no register write.
    localparam ctrl_bundle_t c_ctrl_nop = '0;

    // Number of held entries for a given state.
    function automatic logic [1:0] occupancy_of(input pipe_state_e state);
        logic [1:0] count;
        case (state)
            EMPTY:   count = 2'd0;
            ONE:     count = 2'd1;
            FULL:    count = 2'd2;
            default: count = 2'd0;
        endcase
        return count;
    endfunction

endpackage : pipe_stage_register_pkg
`default_nettype wire

// File: rtl/pipe_stage_register_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that increments by one on each cycle where inc is
//               high and holds at its all-ones value instead of wrapping.
// Ports       : clk_i      - clock
//               reset_n_i  - asynchronous active-low reset, clears the count
//               inc        - increment request for this cycle
//               count      - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import pipe_stage_register_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_count_max = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        // Stop at the maximum value rather than wrapping back to zero.
        if (inc && (r_count_q != c_count_max)) begin
            w_count_d = r_count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign count = r_count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_stage_register.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_register
// Description : Two-entry skid register for a valid/ready pipeline stage.
//               The main slot drives the outputs. The skid slot absorbs one
//               accept while the downstream stalls. This keeps ready_o a pure
//               function of registered state. Ordering is strict FIFO.
//               flush_i discards everything held and the same-cycle input.
//               A saturating counter records back-pressured cycles.
// Ports       : clk_i          - clock
//               reset_n_i      - asynchronous active-low reset
//               flush_i        - synchronous discard of held/incoming entries
//               valid_i/ready_o- upstream handshake
//               ctrl_i/data_i  - upstream payload
//               valid_o/ready_i- downstream handshake
//               ctrl_o/data_o  - downstream payload (bubble when not valid)
//               occupancy_o    - number of held entries (0..2)
//               stall_count_o  - saturating count of stalled output cycles
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_register
    import pipe_stage_register_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = WORD,
    parameter int unsigned           CTRL_WIDTH  = 16,
    parameter logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = CTRL_WIDTH'(c_ctrl_nop),
    parameter int unsigned           CNT_WIDTH   = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [CTRL_WIDTH-1:0] ctrl_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [CTRL_WIDTH-1:0] ctrl_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [1:0]            occupancy_o,
    output logic [CNT_WIDTH-1:0]  stall_count_o
);

    // ------------------------------------------------------------------------
    // State and slot storage
    // ------------------------------------------------------------------------
    pipe_state_e           r_state_q;
    pipe_state_e           w_state_d;

    logic [CTRL_WIDTH-1:0] r_main_ctrl_q;
    logic [CTRL_WIDTH-1:0] w_main_ctrl_d;
    logic [DATA_WIDTH-1:0] r_main_data_q;
    logic [DATA_WIDTH-1:0] w_main_data_d;

    logic [CTRL_WIDTH-1:0] r_skid_ctrl_q;
    logic [CTRL_WIDTH-1:0] w_skid_ctrl_d;
    logic [DATA_WIDTH-1:0] r_skid_data_q;
    logic [DATA_WIDTH-1:0] w_skid_data_d;

    logic                  w_accept;
    logic                  w_emit;
    logic                  w_stall_inc;

    // Handshakes are derived from registered state only, so ready_i never
    // reaches ready_o combinationally.
    assign w_accept    = valid_i && (r_state_q != FULL);
    assign w_emit      = ready_i && (r_state_q != EMPTY);

    // A stalled cycle is one where a valid output is held back downstream.
    // Flush cycles are not counted because the entry is being discarded.
    assign w_stall_inc = (r_state_q != EMPTY) && !ready_i && !flush_i;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state_q     <= EMPTY;
            r_main_ctrl_q <= '0;
            r_main_data_q <= '0;
            r_skid_ctrl_q <= '0;
            r_skid_data_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_main_ctrl_q <= w_main_ctrl_d;
            r_main_data_q <= w_main_data_d;
            r_skid_ctrl_q <= w_skid_ctrl_d;
            r_skid_data_q <= w_skid_data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and slot update
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d     = r_state_q;
        w_main_ctrl_d = r_main_ctrl_q;
        w_main_data_d = r_main_data_q;
        w_skid_ctrl_d = r_skid_ctrl_q;
        w_skid_data_d = r_skid_data_q;

        if (flush_i) begin
            // Flush wins over any accept or emit in the same cycle.
            w_state_d     = EMPTY;
            w_main_ctrl_d = '0;
            w_main_data_d = '0;
            w_skid_ctrl_d = '0;
            w_skid_data_d = '0;
        end else begin
            case (r_state_q)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_d     = ONE;
                        w_main_ctrl_d = ctrl_i;
                        w_main_data_d = data_i;
                    end
                end

                ONE: begin
                    if (w_accept && w_emit) begin
                        // Main leaves and the new entry replaces it directly.
                        w_main_ctrl_d = ctrl_i;
                        w_main_data_d = data_i;
                    end else if (w_accept) begin
                        // Downstream stalled: park the new entry behind main.
                        w_state_d     = FULL;
                        w_skid_ctrl_d = ctrl_i;
                        w_skid_data_d = data_i;
                    end else if (w_emit) begin
                        w_state_d     = EMPTY;
                        w_main_ctrl_d = '0;
                        w_main_data_d = '0;
                    end
                end

                FULL: begin
                    // ready_o is low here, so only an emit can occur.
                    if (w_emit) begin
                        w_state_d     = ONE;
                        w_main_ctrl_d = r_skid_ctrl_q;
                        w_main_data_d = r_skid_data_q;
                        w_skid_ctrl_d = '0;
                        w_skid_data_d = '0;
                    end
                end

                default: begin
                    w_state_d = EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        valid_o     = 1'b0;
        ready_o     = 1'b1;
        ctrl_o      = CTRL_BUBBLE;
        data_o      = '0;
        occupancy_o = occupancy_of(r_state_q);

        case (r_state_q)
            ONE: begin
                valid_o = 1'b1;
                ctrl_o  = r_main_ctrl_q;
                data_o  = r_main_data_q;
            end

            FULL: begin
                valid_o = 1'b1;
                ready_o = 1'b0;
                ctrl_o  = r_main_ctrl_q;
                data_o  = r_main_data_q;
            end

            default: begin
                valid_o = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Back-pressure counter
    // ------------------------------------------------------------------------
    sat_counter #(
        .WIDTH     (CNT_WIDTH)
    ) u_stall_counter (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .inc       (w_stall_inc),
        .count     (stall_count_o)
    );

endmodule : pipe_stage_register
`default_nettype wire

// File: doc/pipe_stage_register.md
PIPE_STAGE_REGISTER -- requirements
Module: pipe_stage_register

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default WORD, meaning the datapath payload width (immediate/operand field).
REQ-002 The block SHALL have parameter CTRL_WIDTH, default 16, meaning the packed control-bundle width (mem/reg-file/ALU select fields).
REQ-003 The block SHALL have parameter CTRL_BUBBLE, default '0, meaning the control word presented whenever no valid entry is output (NOP: no mem write, no mem read, no reg write).
REQ-004 The block SHALL have parameter CNT_WIDTH, default 16, meaning the stall-counter width.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 The block SHALL have port reset_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port flush_i, input, 1 bit: synchronous discard of all held and incoming entries.
REQ-008 The block SHALL have ports valid_i (input, 1 bit) and ready_o (output, 1 bit): the upstream handshake.
REQ-009 The block SHALL have ports ctrl_i (input, CTRL_WIDTH bits) and data_i (input, DATA_WIDTH bits): the upstream payload.
REQ-010 The block SHALL have ports valid_o (output, 1 bit) and ready_i (input, 1 bit): the downstream handshake.
REQ-011 The block SHALL have ports ctrl_o (output, CTRL_WIDTH bits) and data_o (output, DATA_WIDTH bits): the downstream payload.
REQ-012 The block SHALL have port occupancy_o, output, 2 bits: number of held entries (0..2).
REQ-013 The block SHALL have port stall_count_o, output, CNT_WIDTH bits: saturating count of back-pressured cycles.

Function
REQ-014 Accept SHALL occur on a clock edge with valid_i && ready_o; emit SHALL occur on a clock edge with valid_o && ready_i.
REQ-015 The block SHALL be a 2-entry skid register: main slot drives outputs, skid slot absorbs one accept while the downstream stalls.
REQ-016 States: EMPTY (0 held), ONE (main held), FULL (main+skid held); occupancy_o SHALL equal 0/1/2 respectively.
REQ-017 ready_o SHALL be a function of registered state only: 1 in EMPTY/ONE, 0 in FULL; no combinational path from ready_i to ready_o.
REQ-018 valid_o SHALL be 1 in ONE/FULL, 0 in EMPTY; ctrl_o/data_o SHALL equal the main slot when valid_o=1, else CTRL_BUBBLE/'0.
REQ-019 EMPTY transitions: accept -> ONE (main<=input); else stay.
REQ-020 ONE transitions: accept & emit -> ONE (main<=input); accept only -> FULL (skid<=input); emit only -> EMPTY; neither -> stay.
REQ-021 FULL transitions: emit -> ONE (main<=skid); else stay; no accept possible.
REQ-022 Latency SHALL be one cycle from accept into EMPTY to valid_o; order SHALL be strictly FIFO; no entry SHALL be dropped or duplicated.
REQ-023 flush_i=1 SHALL force next state EMPTY, discarding main, skid and any same-cycle input; flush SHALL take priority over accept and emit.
REQ-024 While ready_o=0, the upstream SHALL hold valid_i/payload; the block SHALL ignore payload changes while ready_o=0.
REQ-025 stall_count_o SHALL increment by 1 each cycle valid_o && !ready_i && !flush_i, saturating at 2^CNT_WIDTH-1; flush does not clear it.

Reset
REQ-026 reset_n_i low SHALL asynchronously force: state EMPTY, valid_o 0, ready_o 1, occupancy_o 0, ctrl_o CTRL_BUBBLE, data_o 0, stall_count_o 0, both slots cleared.
REQ-027 Reset asserted mid-operation SHALL discard held entries; first accept is possible on the first edge after deassertion.

Structure
REQ-028 pipe_state_e (EMPTY/ONE/FULL) and the NOP control constant used for CTRL_BUBBLE SHALL live in the shared general-definitions package.
REQ-029 The stall counter SHALL be a sub-module sat_counter (parameter WIDTH; inputs inc, ports clk_i/reset_n_i; output count).

Verification
REQ-030 Reset then valid_i=1, data_i=0x11, ready_i=1 -> valid_o=1, data_o=0x11 next cycle, occupancy_o=1.
REQ-031 ready_i=0, push 0xA1 then 0xA2 -> occupancy_o=2, ready_o=0, stall_count_o increments; ready_i=1 -> outputs 0xA1 then 0xA2 on consecutive cycles.
REQ-032 FULL plus flush_i=1 with valid_i=1, data_i=0xFF -> next cycle valid_o=0, ctrl_o=CTRL_BUBBLE, occupancy_o=0; 0xFF never emitted.
REQ-033 CNT_WIDTH=4, ready_i=0 for 20 cycles with valid_o=1 -> stall_count_o saturates at 15.
REQ-034 Stream 100 random entries with random valid_i/ready_i -> output sequence equals input sequence, and ready_o never depends on same-cycle ready_i.
REQ-035 reset_n_i low asynchronously (between edges) in FULL -> valid_o=0, occupancy_o=0 immediately, before the next edge.
